dmem_arbiter: RTL and testbench

//  Two-requester arbiter that shares the single-port data memory between port A (CPU MEM stage)
//  and port B (DMA / debug loader). Grant decision is combinational per cycle. Fairness and

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter sharing a single-port data memory between the CPU MEM stage (A)
// and a DMA/debug loader (B); combinational grant, registered fairness and lock state.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_stall,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_lock,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2,
        LOCK_B  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_b;
    logic                w_last_b_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic                w_grant_a;
    logic                w_grant_b;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last_b   <= 1'b1;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_b   <= w_last_b_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Next state, fairness owner and A-wait counter
    always_comb begin
        w_state_nxt  = IDLE;
        w_last_b_nxt = r_last_b;
        w_hold_nxt   = '0;
        if (w_grant_a) begin
            w_state_nxt  = SERVE_A;
            w_last_b_nxt = 1'b0;
        end else if (w_grant_b) begin
            w_state_nxt  = b_lock ? LOCK_B : SERVE_B;
            w_last_b_nxt = 1'b1;
        end
        // Counts only while the lock persists and A keeps waiting
        if (r_state == LOCK_B && w_state_nxt == LOCK_B && a_req) begin
            w_hold_nxt = (r_hold_cnt == HOLD_MAX) ? HOLD_MAX : r_hold_cnt + HOLD_W'(1);
        end
    end

    // Grant decision; a dropped lock falls back to the tie rule with B as last owner
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!reset) begin
            if (r_state == LOCK_B && b_req && b_lock && r_hold_cnt < HOLD_MAX) begin
                w_grant_b = 1'b1;
            end else if (r_state == LOCK_B && a_req && r_hold_cnt == HOLD_MAX) begin
                w_grant_a = 1'b1;
            end else if (a_req && b_req) begin
                w_grant_a = r_last_b;
                w_grant_b = ~r_last_b;
            end else begin
                w_grant_a = a_req;
                w_grant_b = b_req;
            end
        end
    end

    // Memory drive and port responses
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (w_grant_a) begin
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            mem_read  = ~a_we;
            mem_write = a_we;
        end else if (w_grant_b) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            mem_read  = ~b_we;
            mem_write = b_we;
        end
    end

    assign a_ack   = w_grant_a;
    assign b_ack   = w_grant_b;
    assign a_stall = a_req & ~w_grant_a;
    assign a_rdata = (w_grant_a && !a_we) ? mem_rdata : '0;
    assign b_rdata = (w_grant_b && !b_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a behavioural ownership/lock model.
module tb_dmem_arbiter;

    localparam int unsigned MH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we, b_lock;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, a_stall, b_ack, mem_read, mem_write;
    logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] env_mem [0:63];
    logic [31:0] mdl_mem [0:63];

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: who owned last, whether B holds a lock, how long A has waited under it
    bit m_last_b;
    bit m_lock;
    int m_wait;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_stall(a_stall),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = env_mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write && !reset) env_mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Every-cycle reference comparison
    always @(negedge clk) begin
        bit ga, gb, lock_after;
        logic [31:0] e_addr, e_wdata, e_ar, e_br;
        bit e_rd, e_wr;
        ga = 1'b0; gb = 1'b0;
        if (reset) begin
            m_last_b = 1'b1; m_lock = 1'b0; m_wait = 0;
            check("rst_a_ack", a_ack, 0);
            check("rst_b_ack", b_ack, 0);
            check("rst_mem_write", mem_write, 0);
            check("rst_mem_read", mem_read, 0);
        end else begin
            if (m_lock && b_req && b_lock && m_wait < MH) gb = 1'b1;
            else if (m_lock && a_req && m_wait == MH) ga = 1'b1;
            else if (a_req && b_req) begin ga = m_last_b; gb = !m_last_b; end
            else begin ga = a_req; gb = b_req; end
            e_addr = ga ? a_addr : gb ? b_addr : 32'h0;
            e_wdata = ga ? a_wdata : gb ? b_wdata : 32'h0;
            e_rd = (ga && !a_we) || (gb && !b_we);
            e_wr = (ga && a_we) || (gb && b_we);
            e_ar = (ga && !a_we) ? mdl_mem[a_addr[7:2]] : 32'h0;
            e_br = (gb && !b_we) ? mdl_mem[b_addr[7:2]] : 32'h0;
            check("a_ack", a_ack, ga);
            check("b_ack", b_ack, gb);
            check("a_stall", a_stall, a_req && !ga);
            check("mem_read", mem_read, e_rd);
            check("mem_write", mem_write, e_wr);
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
            check("a_rdata", a_rdata, e_ar);
            check("b_rdata", b_rdata, e_br);
            if (e_wr) mdl_mem[e_addr[7:2]] = e_wdata;
            lock_after = gb && b_lock;
            m_wait = (m_lock && lock_after && a_req) ? ((m_wait + 1 > MH) ? MH : m_wait + 1) : 0;
            if (ga) m_last_b = 1'b0;
            if (gb) m_last_b = 1'b1;
            m_lock = lock_after;
        end
    end

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] data);
        a_req = req; a_we = we; a_addr = addr; a_wdata = data;
    endtask

    task automatic drive_b(input bit req, input bit we, input bit lock,
                           input logic [31:0] addr, input logic [31:0] data);
        b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = data;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        @(negedge clk);
        next;
        reset = 1'b0;
    endtask

    // Counts consecutive B grants until A is granted, bounded
    task automatic lock_run(output int nb, output bit got_a);
        nb = 0; got_a = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (a_ack) begin got_a = 1'b1; break; end
            if (b_ack) nb++;
            next;
        end
    endtask

    initial begin
        int nb;
        bit got_a;
        bit a_pend, b_pend, a_ackd, b_ackd;
        int lock_p;
        logic [31:0] saved;
        for (int i = 0; i < 64; i++) begin env_mem[i] = '0; mdl_mem[i] = '0; end
        reset = 1'b1;
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle: nothing driven toward memory
        @(negedge clk);
        check("idle_mem_read", mem_read, 0);
        check("idle_mem_write", mem_write, 0);
        check("idle_mem_addr", mem_addr, 0);
        check("idle_rdata", {a_rdata, b_rdata}, 0);

        // A alone: write then read back
        next; drive_a(1, 1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        check("a_wr_ack", {a_ack, a_stall, mem_write}, 3'b101);
        next; drive_a(1, 0, 32'h10, 0);
        @(negedge clk);
        check("a_rd_ack", {a_ack, a_stall}, 2'b10);
        check("a_rd_data", a_rdata, 32'hDEADBEEF);
        next; drive_a(0, 0, 0, 0);

        // Alternating grants on sustained contention from reset
        pulse_reset;
        drive_a(1, 0, 32'h10, 0);
        drive_b(1, 0, 0, 32'h14, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("alt_grant", {a_ack, b_ack, a_stall}, (i % 2 == 0) ? 3'b100 : 3'b011);
            next;
        end
        drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);

        // Write collision at 0x20: A first, then B retries
        pulse_reset;
        drive_a(1, 1, 32'h20, 32'h1111);
        drive_b(1, 1, 0, 32'h20, 32'h2222);
        @(negedge clk);
        check("coll_first", {a_ack, b_ack}, 2'b10);
        check("coll_first_wdata", mem_wdata, 32'h1111);
        next; drive_a(1, 0, 32'h20, 0);
        @(negedge clk);
        check("coll_mem_after_a", env_mem[8], 32'h1111);
        check("coll_retry", {a_ack, b_ack}, 2'b01);
        next; drive_b(0, 0, 0, 0, 0);
        @(negedge clk);
        check("coll_final", a_rdata, 32'h2222);
        next; drive_a(0, 0, 0, 0);

        // B locks alone, then A waits: MAX_HOLD locked grants before a forced yield
        drive_b(1, 0, 1, 32'h30, 0);
        @(negedge clk);
        check("lock_entry", b_ack, 1);
        next; drive_a(1, 0, 32'h34, 0);
        lock_run(nb, got_a);
        check("lock_yield_seen", got_a, 1);
        check("lock_run_len", nb, MH);
        next;
        @(negedge clk);
        check("lock_resume", {a_ack, b_ack}, 2'b01);
        next; drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);

        // Reset in the middle of a locked write burst with A waiting
        pulse_reset;
        drive_b(1, 1, 1, 32'h3C, 32'h1);
        next; drive_a(1, 0, 32'h34, 0);
        repeat (5) begin next; b_wdata = b_wdata + 1; end
        saved = env_mem[14];
        drive_b(1, 1, 1, 32'h38, 32'hBAD0BAD0);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_burst_quiet", {mem_write, a_ack, b_ack}, 3'b000);
        next;
        @(negedge clk);
        next; reset = 1'b0;
        drive_b(1, 0, 1, 32'h30, 0);
        @(negedge clk);
        check("rst_tie_to_a", {a_ack, b_ack}, 2'b10);
        check("rst_no_write", env_mem[14], saved);
        next;
        // Entry grant to B, then a fresh MAX_HOLD locked cycles
        lock_run(nb, got_a);
        check("rst_hold_yield", got_a, 1);
        check("rst_hold_run", nb, 1 + MH);
        next; drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);

        // Randomized traffic honouring hold-until-ack
        a_pend = 0; b_pend = 0; a_ackd = 0; b_ackd = 0;
        for (int seg = 0; seg < 10; seg++) begin
            lock_p = (seg % 3 == 0) ? 100 : int'($urandom_range(0, 80));
            for (int cyc = 0; cyc < 200; cyc++) begin
                next;
                reset = ($urandom_range(0, 299) == 0);
                if (!a_pend || a_ackd) begin
                    a_pend = ($urandom_range(0, 99) < 60);
                    drive_a(a_pend, $urandom_range(0, 1) == 1, {24'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
                end
                if (!b_pend || b_ackd) begin
                    b_pend = ($urandom_range(0, 99) < 85);
                    drive_b(b_pend, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < lock_p,
                            {24'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
                end
                @(negedge clk);
                a_ackd = a_ack; b_ackd = b_ack;
                if (reset) begin
                    a_pend = 0; b_pend = 0;
                end
            end
        end
        next; reset = 1'b0;
        drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
